// File: rtl/alu_issue_stage.sv
// Decode/issue front end for alu_top: two-stage D/E pipeline with E-to-D
// forwarding, 32-entry register file and registered ALU operand/field drive.
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             stall,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  output logic [11:0]      alu_imm,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_rd,
  output logic             wb_valid,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             illegal,
  output logic [31:0]      retire_count,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [WIDTH-1:0] r_regfile [32];

  logic             r_e_valid;
  logic [4:0]       r_e_rd;
  logic [WIDTH-1:0] r_rs1;
  logic [WIDTH-1:0] r_rs2;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic [6:0]       r_funct7;
  logic [11:0]      r_imm;
  logic [4:0]       r_shamt;
  logic             r_wb_valid;
  logic [4:0]       r_wb_addr;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_illegal;
  logic [31:0]      r_retire_count;

  logic [6:0]       w_opcode;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1_idx;
  logic [4:0]       w_rs2_idx;
  logic             w_legal;
  logic             w_accept;
  logic             w_commit;
  logic             w_fwd_ok;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;

  assign w_opcode  = instr[6:0];
  assign w_rd      = instr[11:7];
  assign w_rs1_idx = instr[19:15];
  assign w_rs2_idx = instr[24:20];
  assign w_legal   = (w_opcode == OPC_OP) || (w_opcode == OPC_OP_IMM);

  assign instr_ready = !stall && !rst;
  assign w_accept    = instr_valid && instr_ready;
  assign w_commit    = r_e_valid && !stall && (r_e_rd != 5'd0);
  assign w_fwd_ok    = r_e_valid && (r_e_rd != 5'd0);

  // Forward from the live ALU result so a same-edge commit never yields a stale read.
  always_comb begin
    w_rs1_val = r_regfile[w_rs1_idx];
    if (w_rs1_idx == 5'd0)
      w_rs1_val = '0;
    else if (w_fwd_ok && (w_rs1_idx == r_e_rd))
      w_rs1_val = alu_rd;
  end

  always_comb begin
    w_rs2_val = r_regfile[w_rs2_idx];
    if (w_rs2_idx == 5'd0)
      w_rs2_val = '0;
    else if (w_fwd_ok && (w_rs2_idx == r_e_rd))
      w_rs2_val = alu_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_valid <= 1'b0;
      r_e_rd    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
    end else if (!stall) begin
      if (w_accept && w_legal) begin
        r_e_valid <= 1'b1;
        r_e_rd    <= w_rd;
        r_rs1     <= w_rs1_val;
        r_rs2     <= w_rs2_val;
        r_opcode  <= w_opcode;
        r_funct3  <= instr[14:12];
        r_funct7  <= instr[31:25];
        r_imm     <= instr[31:20];
        r_shamt   <= instr[24:20];
      end else begin
        r_e_valid <= 1'b0;
        r_e_rd    <= '0;
        r_rs1     <= '0;
        r_rs2     <= '0;
        r_opcode  <= '0;
        r_funct3  <= '0;
        r_funct7  <= '0;
        r_imm     <= '0;
        r_shamt   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regfile[i] <= '0;
    end else if (w_commit) begin
      r_regfile[r_e_rd] <= alu_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_addr      <= '0;
      r_wb_data      <= '0;
      r_illegal      <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_wb_valid <= w_commit;
      if (w_commit) begin
        r_wb_addr <= r_e_rd;
        r_wb_data <= alu_rd;
      end
      r_illegal <= w_accept && !w_legal;
      if (r_e_valid && !stall)
        r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign alu_rs1      = r_rs1;
  assign alu_rs2      = r_rs2;
  assign alu_opcode   = r_opcode;
  assign alu_funct3   = r_funct3;
  assign alu_funct7   = r_funct7;
  assign alu_imm      = r_imm;
  assign alu_shamt    = r_shamt;
  assign wb_valid     = r_wb_valid;
  assign wb_addr      = r_wb_addr;
  assign wb_data      = r_wb_data;
  assign illegal      = r_illegal;
  assign retire_count = r_retire_count;
  assign dbg_data     = (dbg_addr == 5'd0) ? '0 : r_regfile[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small ALU stand-in driving alu_rd.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic             stall;
  logic [WIDTH-1:0] alu_rs1, alu_rs2;
  logic [6:0]       alu_opcode;
  logic [2:0]       alu_funct3;
  logic [6:0]       alu_funct7;
  logic [11:0]      alu_imm;
  logic [4:0]       alu_shamt;
  logic [WIDTH-1:0] alu_rd;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             illegal;
  logic [31:0]      retire_count;
  logic [4:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .stall(stall),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_imm(alu_imm),
    .alu_shamt(alu_shamt), .alu_rd(alu_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .retire_count(retire_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Minimal ALU: ADD/SUB/AND for OP, ADDI/ANDI for OP-IMM.
  always_comb begin
    alu_rd = '0;
    case (alu_opcode)
      7'b0110011: begin
        if (alu_funct3 == 3'd0) alu_rd = alu_funct7[5] ? (alu_rs1 - alu_rs2) : (alu_rs1 + alu_rs2);
        else if (alu_funct3 == 3'd7) alu_rd = alu_rs1 & alu_rs2;
      end
      7'b0010011: begin
        if (alu_funct3 == 3'd0) alu_rd = alu_rs1 + {{20{alu_imm[11]}}, alu_imm};
        else if (alu_funct3 == 3'd7) alu_rd = alu_rs1 & {{20{alu_imm[11]}}, alu_imm};
      end
      default: alu_rd = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; stall = 1'b0; dbg_addr = 5'd0;
    tick(); tick();
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_opcode", {25'd0, alu_opcode}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // ADDI x1,x0,5
    rst = 1'b0; instr_valid = 1'b1; instr = 32'h00500093; #1;
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("e_opcode", {25'd0, alu_opcode}, 32'h13);
    chk("e_imm", {20'd0, alu_imm}, 32'd5);
    chk("e_alu_rd", alu_rd, 32'd5);
    chk("e_no_wb_yet", {31'd0, wb_valid}, 32'd0);
    tick();
    dbg_addr = 5'd1; #1;
    chk("wb1_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb1_addr", {27'd0, wb_addr}, 32'd1);
    chk("wb1_data", wb_data, 32'd5);
    chk("dbg_x1", dbg_data, 32'd5);
    chk("retire1", retire_count, 32'd1);
    tick();
    chk("wb1_pulse_end", {31'd0, wb_valid}, 32'd0);

    // Back-to-back dependent chain
    instr_valid = 1'b1; instr = 32'h00500093;
    tick();
    instr = 32'h00308113;
    chk("b2b_ready0", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("fwd_rs1_x1", alu_rs1, 32'd5);
    chk("b2b_wb_x1", {31'd0, wb_valid}, 32'd1);
    instr = 32'h401101B3;
    chk("b2b_ready1", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("fwd_rs1_x2", alu_rs1, 32'd8);
    chk("rf_rs2_x1", alu_rs2, 32'd5);
    chk("b2b_wb_addr2", {27'd0, wb_addr}, 32'd2);
    chk("b2b_wb_data2", wb_data, 32'd8);
    tick();
    chk("b2b_wb_addr3", {27'd0, wb_addr}, 32'd3);
    chk("b2b_wb_data3", wb_data, 32'd3);
    dbg_addr = 5'd2; #1;
    chk("dbg_x2", dbg_data, 32'd8);
    dbg_addr = 5'd3; #1;
    chk("dbg_x3", dbg_data, 32'd3);
    chk("retire4", retire_count, 32'd4);

    // x0 destination, then ADD x4,x0,x0
    instr_valid = 1'b1; instr = 32'h00700013;
    tick();
    instr = 32'h00000233;
    tick();
    instr_valid = 1'b0;
    chk("x0_no_wb", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("x4_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("x4_wb_addr", {27'd0, wb_addr}, 32'd4);
    chk("x4_wb_data", wb_data, 32'd0);
    dbg_addr = 5'd0; #1;
    chk("dbg_x0", dbg_data, 32'd0);
    chk("retire6", retire_count, 32'd6);

    // Illegal opcode (LW)
    instr_valid = 1'b1; instr = 32'h00000003;
    tick();
    instr_valid = 1'b0;
    chk("illegal_pulse", {31'd0, illegal}, 32'd1);
    chk("illegal_opcode", {25'd0, alu_opcode}, 32'd0);
    chk("illegal_alu_rd", alu_rd, 32'd0);
    tick();
    chk("illegal_end", {31'd0, illegal}, 32'd0);
    chk("illegal_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("illegal_retire", retire_count, 32'd6);

    // ADDI x5,x0,9 then stall three cycles
    instr_valid = 1'b1; instr = 32'h00900293;
    tick();
    stall = 1'b1; instr = 32'h00700013; #1;
    chk("stall_ready", {31'd0, instr_ready}, 32'd0);
    dbg_addr = 5'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_opcode", {25'd0, alu_opcode}, 32'h13);
      chk("stall_imm", {20'd0, alu_imm}, 32'd9);
      chk("stall_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("stall_no_commit", dbg_data, 32'd0);
    end
    chk("stall_retire", retire_count, 32'd6);
    stall = 1'b0; instr_valid = 1'b0;
    tick();
    chk("unstall_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("unstall_wb_addr", {27'd0, wb_addr}, 32'd5);
    chk("unstall_wb_data", wb_data, 32'd9);
    chk("dbg_x5", dbg_data, 32'd9);
    chk("retire7", retire_count, 32'd7);
    chk("unstall_bubble", {25'd0, alu_opcode}, 32'd0);

    // ADDI x6,x0,1 then reset
    instr_valid = 1'b1; instr = 32'h00100313;
    tick();
    rst = 1'b1; instr = 32'h00500093; #1;
    chk("rst_mid_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    dbg_addr = 5'd6; #1;
    chk("rst_mid_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_x6", dbg_data, 32'd0);
    chk("rst_mid_retire", retire_count, 32'd0);
    chk("rst_mid_opcode", {25'd0, alu_opcode}, 32'd0);
    chk("rst_mid_rs1", alu_rs1, 32'd0);
    chk("rst_mid_imm", {20'd0, alu_imm}, 32'd0);
    dbg_addr = 5'd5; #1;
    chk("rst_mid_x5", dbg_data, 32'd0);
    rst = 1'b0; instr_valid = 1'b0;
    tick();
    chk("post_rst_no_accept", {31'd0, wb_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
